// File: rtl/grid_access_arbiter_pkg.sv
// Shared level-grid geometry, cell codes and arbiter state encoding.
package grid_defs;

  localparam int GRID_W   = 40;
  localparam int GRID_H   = 30;
  localparam int GRID_X_W = 6;
  localparam int GRID_Y_W = 5;
  localparam int CELL_W   = 3;

  localparam logic [CELL_W-1:0] CELL_AIR   = 3'd0;
  localparam logic [CELL_W-1:0] CELL_ENEMY = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/grid_access_arbiter_rr_picker.sv
// Round-robin picker: first asserted request after the last owner, wrapping mod N_REQ.
module rr_picker #(
  parameter int N_REQ   = 3,
  parameter int OWNER_W = 2
) (
  input  logic [N_REQ-1:0]   req_i,
  input  logic [OWNER_W-1:0] last_owner_i,
  output logic [OWNER_W-1:0] pick_o,
  output logic               valid_o
);

  int idx;

  // Scan farthest-first so the nearest candidate after last_owner overwrites.
  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last_owner_i) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_i[idx]) begin
        pick_o  = OWNER_W'(idx);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_access_arbiter.sv
// Round-robin whole-transaction arbiter for the single-port level grid, with watchdog.
module grid_access_arbiter
  import grid_defs::*;
#(
  parameter int N_REQ   = 3,
  parameter int OWNER_W = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0]             done,
  input  logic [GRID_X_W*N_REQ-1:0]    req_x,
  input  logic [GRID_Y_W*N_REQ-1:0]    req_y,
  input  logic [N_REQ-1:0]             req_write,
  input  logic [CELL_W*N_REQ-1:0]      req_in,
  output logic [N_REQ-1:0]             grant,
  output logic                         busy,
  output logic [OWNER_W-1:0]           owner,
  output logic                         timeout_flag,
  output logic [GRID_X_W-1:0]          grid_x,
  output logic [GRID_Y_W-1:0]          grid_y,
  output logic                         grid_write,
  output logic [CELL_W-1:0]            grid_in,
  output logic [CELL_W-1:0]            grid_out_q,
  input  logic [CELL_W-1:0]            grid_out
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [OWNER_W-1:0] OWNER_RST = OWNER_W'(N_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               tflag_q, tflag_d;

  logic [OWNER_W-1:0] pick;
  logic               pick_valid;
  logic               own_done, own_req, wdog_last;
  logic               mux_write;

  rr_picker #(.N_REQ(N_REQ), .OWNER_W(OWNER_W)) u_picker (
    .req_i        (req),
    .last_owner_i (owner_q),
    .pick_o       (pick),
    .valid_o      (pick_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= OWNER_RST;
      wdog_q  <= '0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      wdog_q  <= wdog_d;
      tflag_q <= tflag_d;
    end
  end

  assign own_done  = done[owner_q];
  assign own_req   = req[owner_q];
  assign wdog_last = (wdog_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    wdog_d  = wdog_q;
    tflag_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d       = ST_OWNED;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          wdog_d        = '0;
        end
      end
      ST_OWNED: begin
        // A dropped request counts as done; only a genuine hang raises the flag.
        if (own_done || !own_req || wdog_last) begin
          state_d = ST_RELEASE;
          grant_d = '0;
          wdog_d  = '0;
          tflag_d = wdog_last && !own_done && own_req;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        wdog_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        wdog_d  = '0;
      end
    endcase
  end

  always_comb begin
    grid_x    = '0;
    grid_y    = '0;
    grid_in   = '0;
    mux_write = 1'b0;
    if (state_q == ST_OWNED) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (owner_q == OWNER_W'(i)) begin
          grid_x    = req_x[GRID_X_W*i +: GRID_X_W];
          grid_y    = req_y[GRID_Y_W*i +: GRID_Y_W];
          grid_in   = req_in[CELL_W*i +: CELL_W];
          mux_write = req_write[i];
        end
      end
    end
  end

  // Gating by reset keeps a write from landing on the edge that aborts the owner.
  assign grid_write   = mux_write && !reset;
  assign grant        = grant_q;
  assign busy         = (state_q == ST_OWNED);
  assign owner        = owner_q;
  assign timeout_flag = tflag_q;
  assign grid_out_q   = grid_out;

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Directed table-driven bench for grid_access_arbiter (N_REQ=3, TIMEOUT=16).
module tb_grid_access_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req, done, req_write, req_in_unused;
  logic [17:0] req_x;
  logic [14:0] req_y;
  logic [8:0]  req_in;
  logic [2:0]  grant;
  logic        busy;
  logic [1:0]  owner;
  logic        timeout_flag;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic        grid_write;
  logic [2:0]  grid_in, grid_out_q, grid_out;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  grid_access_arbiter #(.N_REQ(3), .OWNER_W(2), .TIMEOUT(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .done         (done),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_write    (req_write),
    .req_in       (req_in),
    .grant        (grant),
    .busy         (busy),
    .owner        (owner),
    .timeout_flag (timeout_flag),
    .grid_x       (grid_x),
    .grid_y       (grid_y),
    .grid_write   (grid_write),
    .grid_in      (grid_in),
    .grid_out_q   (grid_out_q),
    .grid_out     (grid_out)
  );

  typedef struct {
    logic [2:0] req, done, wr;
    logic [2:0] g;
    logic       b;
    logic [1:0] o;
    logic [5:0] gx;
    logic [4:0] gy;
    logic       gw;
    logic [2:0] gi;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    else passed++;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; done = '0; req_write = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    req_x  = {6'd30, 6'd12, 6'd5};
    req_y  = {5'd20, 5'd7, 5'd3};
    req_in = {3'd1, 3'd4, 3'd2};
    req_in_unused = '0;
    grid_out = '0;

    // req, done, wr, grant, busy, owner, gx, gy, gw, gi
    vecs[0]  = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 2'd2, 6'd0,  5'd0,  1'b0, 3'd0};
    vecs[1]  = '{3'b111, 3'b000, 3'b001, 3'b001, 1'b1, 2'd0, 6'd5,  5'd3,  1'b1, 3'd2};
    vecs[2]  = '{3'b111, 3'b001, 3'b000, 3'b001, 1'b1, 2'd0, 6'd5,  5'd3,  1'b0, 3'd2};
    vecs[3]  = '{3'b111, 3'b000, 3'b111, 3'b000, 1'b0, 2'd0, 6'd0,  5'd0,  1'b0, 3'd0};
    vecs[4]  = '{3'b111, 3'b000, 3'b111, 3'b000, 1'b0, 2'd0, 6'd0,  5'd0,  1'b0, 3'd0};
    vecs[5]  = '{3'b111, 3'b000, 3'b001, 3'b010, 1'b1, 2'd1, 6'd12, 5'd7,  1'b0, 3'd4};
    vecs[6]  = '{3'b111, 3'b001, 3'b010, 3'b010, 1'b1, 2'd1, 6'd12, 5'd7,  1'b1, 3'd4};
    vecs[7]  = '{3'b111, 3'b010, 3'b000, 3'b010, 1'b1, 2'd1, 6'd12, 5'd7,  1'b0, 3'd4};
    vecs[8]  = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1, 6'd0,  5'd0,  1'b0, 3'd0};
    vecs[9]  = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1, 6'd0,  5'd0,  1'b0, 3'd0};
    vecs[10] = '{3'b111, 3'b100, 3'b100, 3'b100, 1'b1, 2'd2, 6'd30, 5'd20, 1'b1, 3'd1};
    vecs[11] = '{3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 2'd2, 6'd0,  5'd0,  1'b0, 3'd0};
    vecs[12] = '{3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 2'd2, 6'd0,  5'd0,  1'b0, 3'd0};
    vecs[13] = '{3'b001, 3'b000, 3'b000, 3'b001, 1'b1, 2'd0, 6'd5,  5'd3,  1'b0, 3'd2};

    do_reset();
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 2);
    chk("rst_tflag", 32'(timeout_flag), 0);
    chk("rst_gwrite", 32'(grid_write), 0);
    grid_out = 3'd5;
    #1;
    chk("grid_out_pass", 32'(grid_out_q), 5);

    // Round-robin rotation and owner-only muxing
    for (int v = 0; v < 14; v++) begin
      req = vecs[v].req; done = vecs[v].done; req_write = vecs[v].wr;
      #1;
      chk($sformatf("v%0d_grant", v), 32'(grant), 32'(vecs[v].g));
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].b));
      chk($sformatf("v%0d_owner", v), 32'(owner), 32'(vecs[v].o));
      chk($sformatf("v%0d_tflag", v), 32'(timeout_flag), 0);
      chk($sformatf("v%0d_gx", v), 32'(grid_x), 32'(vecs[v].gx));
      chk($sformatf("v%0d_gy", v), 32'(grid_y), 32'(vecs[v].gy));
      chk($sformatf("v%0d_gw", v), 32'(grid_write), 32'(vecs[v].gw));
      chk($sformatf("v%0d_gi", v), 32'(grid_in), 32'(vecs[v].gi));
      step();
    end

    // Hung owner: watchdog forces release after 16 owned cycles
    do_reset();
    req = 3'b010;
    step();
    chk("to_grant", 32'(grant), 32'(3'b010));
    n = 0;
    while (grant != 3'b000 && n < 40) begin
      chk("to_no_early_flag", 32'(timeout_flag), 0);
      n++;
      step();
    end
    chk("to_owned_cycles", 32'(n), 16);
    chk("to_flag_pulse", 32'(timeout_flag), 1);
    step();
    chk("to_flag_clear", 32'(timeout_flag), 0);
    chk("to_idle_grant", 32'(grant), 0);
    step();
    chk("to_regrant", 32'(grant), 32'(3'b010));

    // Owner drops request without done
    do_reset();
    req = 3'b001;
    step();
    step();
    chk("drop_held", 32'(grant), 32'(3'b001));
    req = 3'b000;
    step();
    chk("drop_grant", 32'(grant), 0);
    chk("drop_busy", 32'(busy), 0);
    chk("drop_tflag", 32'(timeout_flag), 0);

    // done on the watchdog's last cycle is a normal release
    do_reset();
    req = 3'b100;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("wd_last_held", 32'(grant), 32'(3'b100));
    done = 3'b100;
    step();
    done = 3'b000;
    chk("wd_last_grant", 32'(grant), 0);
    chk("wd_last_tflag", 32'(timeout_flag), 0);

    // Reset during an owned write
    do_reset();
    req = 3'b010; req_write = 3'b010;
    step();
    step();
    #1;
    chk("rmid_write_pre", 32'(grid_write), 1);
    reset = 1'b1;
    #1;
    chk("rmid_write_gated", 32'(grid_write), 0);
    step();
    reset = 1'b0;
    chk("rmid_grant", 32'(grant), 0);
    chk("rmid_owner", 32'(owner), 2);
    req = 3'b011;
    step();
    chk("rmid_first_pick", 32'(grant), 32'(3'b001));
    chk("rmid_first_owner", 32'(owner), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
